// File: rtl/idma_desc64_submit_queue.sv
// Doorbell-fed per-channel descriptor submission queues sitting in front of a regbus register file.
// Optional IDMA_DESC64_SUBMIT_ERR_ON_FULL_EN: a doorbell write to a full channel errors instead of stalling.
package idma_desc64_submit_queue_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module idma_desc64_submit_queue #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned BufDepth     = 4,
    parameter int unsigned DataWidth    = 64,
    parameter logic [31:0] DoorbellBase = 32'h0,
    parameter logic [31:0] ChanStride   = 32'h8,
    parameter type         reg_req_t    = idma_desc64_submit_queue_pkg::reg_req_t,
    parameter type         reg_rsp_t    = idma_desc64_submit_queue_pkg::reg_rsp_t
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  reg_req_t                                          reg_req_i,
    output reg_rsp_t                                          reg_rsp_o,
    output reg_req_t                                          reg_req_o,
    input  reg_rsp_t                                          reg_rsp_i,
    output logic [NumChannels-1:0][DataWidth-1:0]             desc_addr_o,
    output logic [NumChannels-1:0]                            desc_valid_o,
    input  logic [NumChannels-1:0]                            desc_ready_i,
    output logic [NumChannels-1:0][$clog2(BufDepth+1)-1:0]    fill_o
);

    localparam int unsigned CntW   = $clog2(BufDepth + 1);
    localparam int unsigned PtrW   = $clog2(BufDepth);
    localparam int unsigned ChW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned AddrW  = $bits(reg_req_i.addr);
    localparam int unsigned RdataW = $bits(reg_rsp_o.rdata);

    logic [CntW-1:0]      cnt_q   [NumChannels];
    logic [CntW-1:0]      cnt_d   [NumChannels];
    logic [PtrW-1:0]      wptr_q  [NumChannels];
    logic [PtrW-1:0]      wptr_d  [NumChannels];
    logic [PtrW-1:0]      rptr_q  [NumChannels];
    logic [PtrW-1:0]      rptr_d  [NumChannels];
    logic [DataWidth-1:0] mem_q   [NumChannels][BufDepth];

    logic                   db_hit;
    logic [ChW-1:0]         db_ch;
    logic                   db_full;
    logic [NumChannels-1:0] push;
    logic [NumChannels-1:0] pop;
    logic [DataWidth-1:0]   push_data;

    assign push_data = DataWidth'(reg_req_i.wdata);

    always_comb begin
        db_hit = 1'b0;
        db_ch  = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (reg_req_i.addr == AddrW'(DoorbellBase + c * ChanStride)) begin
                db_hit = reg_req_i.valid;
                db_ch  = ChW'(c);
            end
        end
    end

    // Full is judged on the registered count so a same-cycle pop never frees a slot for the push.
    always_comb begin
        reg_req_o = reg_req_i;
        reg_rsp_o = reg_rsp_i;
        push      = '0;
        db_full   = (cnt_q[db_ch] == CntW'(BufDepth));
        if (db_hit) begin
            reg_req_o.valid = 1'b0;
            reg_rsp_o       = '0;
            if (!reg_req_i.write) begin
                reg_rsp_o.ready = 1'b1;
                reg_rsp_o.rdata = RdataW'(cnt_q[db_ch]);
            end else if (!(&reg_req_i.wstrb)) begin
                reg_rsp_o.ready = 1'b1;
                reg_rsp_o.error = 1'b1;
            end else if (db_full) begin
`ifdef IDMA_DESC64_SUBMIT_ERR_ON_FULL_EN
                reg_rsp_o.ready = 1'b1;
                reg_rsp_o.error = 1'b1;
`else
                reg_rsp_o.ready = 1'b0;
`endif
            end else begin
                reg_rsp_o.ready = 1'b1;
                push[db_ch]     = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NumChannels; c++) begin
            pop[c]          = (cnt_q[c] != '0) && desc_ready_i[c];
            cnt_d[c]        = cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
            wptr_d[c]       = wptr_q[c] + PtrW'(push[c]);
            rptr_d[c]       = rptr_q[c] + PtrW'(pop[c]);
            desc_valid_o[c] = (cnt_q[c] != '0);
            fill_o[c]       = cnt_q[c];
            desc_addr_o[c]  = desc_valid_o[c] ? mem_q[c][rptr_q[c]] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '{default: '0};
            wptr_q <= '{default: '0};
            rptr_q <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the read side masks it with the count.
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_idma_desc64_submit_queue.sv
// Directed bench for idma_desc64_submit_queue (4 channels, depth 4, doorbells at 0x0/0x8/0x10/0x18).
module tb_idma_desc64_submit_queue;
    import idma_desc64_submit_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    reg_req_t          req;
    reg_rsp_t          rsp;
    reg_req_t          fwd_req;
    reg_rsp_t          fwd_rsp;
    logic [3:0][63:0]  desc_addr;
    logic [3:0]        desc_valid;
    logic [3:0]        desc_ready;
    logic [3:0][2:0]   fill;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    idma_desc64_submit_queue #(
        .NumChannels (4),
        .BufDepth    (4),
        .DataWidth   (64),
        .DoorbellBase(32'h0),
        .ChanStride  (32'h8),
        .reg_req_t   (reg_req_t),
        .reg_rsp_t   (reg_rsp_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .reg_req_o   (fwd_req),
        .reg_rsp_i   (fwd_rsp),
        .desc_addr_o (desc_addr),
        .desc_valid_o(desc_valid),
        .desc_ready_i(desc_ready),
        .fill_o      (fill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        req.addr  = a;
        req.write = 1'b1;
        req.wdata = d;
        req.wstrb = s;
        req.valid = 1'b1;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        req.addr  = a;
        req.write = 1'b0;
        req.wdata = '0;
        req.wstrb = '0;
        req.valid = 1'b1;
    endtask

    task automatic bus_idle();
        req = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_q[$];
    int unsigned pushed;
    int unsigned popped;

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        fwd_rsp    = '0;
        desc_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(desc_valid), 64'h0);
        chk("rst_fill", 64'(fill), 64'h0);
        chk("rst_addr", desc_addr[0] | desc_addr[1] | desc_addr[2] | desc_addr[3], 64'h0);

        // first cycle after release: doorbell write to channel 0
        @(negedge clk);
        rst_n = 1'b1;
        bus_wr(32'h0, 64'h1000, 8'hFF);
        #1;
        chk("db0_ready", 64'(rsp.ready), 64'h1);
        chk("db0_error", 64'(rsp.error), 64'h0);
        chk("db0_no_fwd", 64'(fwd_req.valid), 64'h0);
        @(posedge clk);
        #1;
        bus_idle();
        chk("ch0_valid", 64'(desc_valid[0]), 64'h1);
        chk("ch0_addr", desc_addr[0], 64'h1000);
        chk("ch0_fill", 64'(fill[0]), 64'h1);

        bus_rd(32'h0);
        #2;
        chk("rd0_ready", 64'(rsp.ready), 64'h1);
        chk("rd0_rdata", rsp.rdata, 64'h1);
        chk("rd0_error", 64'(rsp.error), 64'h0);
        next_cycle();

        // non-doorbell passthrough
        bus_wr(32'h40, 64'h55AA, 8'hFF);
        fwd_rsp.rdata = 64'hDEAD_BEEF;
        fwd_rsp.error = 1'b1;
        fwd_rsp.ready = 1'b1;
        #2;
        chk("fwd_valid", 64'(fwd_req.valid), 64'h1);
        chk("fwd_addr", 64'(fwd_req.addr), 64'h40);
        chk("fwd_wdata", fwd_req.wdata, 64'h55AA);
        chk("fwd_rdata", rsp.rdata, 64'hDEAD_BEEF);
        chk("fwd_err_rdy", 64'({rsp.error, rsp.ready}), 64'h3);
        next_cycle();
        fwd_rsp = '0;

        // partial strobe on channel 3
        bus_wr(32'h18, 64'h777, 8'h0F);
        #2;
        chk("strb_ready", 64'(rsp.ready), 64'h1);
        chk("strb_error", 64'(rsp.error), 64'h1);
        next_cycle();
        bus_idle();
        chk("strb_fill", 64'(fill[3]), 64'h0);
        chk("strb_valid", 64'(desc_valid[3]), 64'h0);

        // fill channel 1
        for (int i = 0; i < 4; i++) begin
            bus_wr(32'h8, 64'hA0 + 64'(i), 8'hFF);
            #2;
            chk("ch1_push_ready", 64'({rsp.error, rsp.ready}), 64'h1);
            next_cycle();
        end
        chk("ch1_fill4", 64'(fill[1]), 64'h4);
        bus_wr(32'h8, 64'hA4, 8'hFF);
        #2;
`ifdef IDMA_DESC64_SUBMIT_ERR_ON_FULL_EN
        chk("full_err", 64'({rsp.error, rsp.ready}), 64'h3);
        next_cycle();
        bus_idle();
        chk("full_fill", 64'(fill[1]), 64'h4);
        chk("full_head", desc_addr[1], 64'hA0);
        desc_ready[1] = 1'b1;
        next_cycle();
        desc_ready[1] = 1'b0;
        chk("pop_fill", 64'(fill[1]), 64'h3);
        exp_q = '{64'hA1, 64'hA2, 64'hA3};
`else
        chk("full_stall", 64'(rsp.ready), 64'h0);
        next_cycle();
        chk("full_stall2", 64'(rsp.ready), 64'h0);
        chk("full_fill", 64'(fill[1]), 64'h4);
        chk("indep_ch0", 64'(desc_valid[0]), 64'h1);
        desc_ready[1] = 1'b1;
        #1;
        chk("full_pop_same_cycle", 64'(rsp.ready), 64'h0);
        next_cycle();
        desc_ready[1] = 1'b0;
        chk("pop_fill", 64'(fill[1]), 64'h3);
        chk("pop_head", desc_addr[1], 64'hA1);
        #1;
        chk("stall_done", 64'({rsp.error, rsp.ready}), 64'h1);
        next_cycle();
        bus_idle();
        chk("refill", 64'(fill[1]), 64'h4);
        exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
`endif
        desc_ready[1] = 1'b1;
        foreach (exp_q[k]) begin
            chk("ch1_order", desc_addr[1], exp_q[k]);
            next_cycle();
        end
        desc_ready[1] = 1'b0;
        chk("ch1_empty_fill", 64'(fill[1]), 64'h0);
        chk("ch1_empty_valid", 64'(desc_valid[1]), 64'h0);

        desc_ready[0] = 1'b1;
        next_cycle();
        desc_ready[0] = 1'b0;
        chk("ch0_drained", 64'(fill[0]), 64'h0);

        // channel 2: ten entries through with random consumer backpressure
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
            if (pushed < 10) bus_wr(32'h10, 64'(pushed), 8'hFF);
            else bus_idle();
            desc_ready[2] = 1'($urandom_range(0, 1));
            #2;
            if (desc_valid[2] !== (fill[2] != 3'd0))
                chk("ch2_valid_vs_fill", 64'(desc_valid[2]), 64'(fill[2] != 3'd0));
            if (desc_valid[2] && desc_ready[2]) begin
                chk("ch2_order", desc_addr[2], 64'(popped));
                popped++;
            end
            if (req.valid && rsp.ready && !rsp.error) pushed++;
            next_cycle();
        end
        bus_idle();
        desc_ready[2] = 1'b0;
        chk("ch2_popped", 64'(popped), 64'd10);
        chk("ch2_fill0", 64'(fill[2]), 64'h0);

        // reset mid-operation with three entries on channel 3
        for (int i = 0; i < 3; i++) begin
            bus_wr(32'h18, 64'hC0 + 64'(i), 8'hFF);
            next_cycle();
        end
        bus_idle();
        chk("ch3_fill3", 64'(fill[3]), 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(desc_valid), 64'h0);
        chk("mrst_fill", 64'(fill), 64'h0);
        chk("mrst_addr", desc_addr[3], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        chk("post_rst_valid", 64'(desc_valid), 64'h0);
        chk("post_rst_fill", 64'(fill), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
